bit_serial_adder: RTL and testbench

Sequential LSB-first adder that consumes two WIDTH-bit operands and produces their sum one bit per clock through a single full-adder cell (two HalfAdder instances plus an OR) and a carry flip-flop. It sits directly above the HalfAdder stage and is the first clocked arithmetic block in the datapath. It trades latency for area: one full-adder slice regardless of WIDTH.

---
 rtl/bit_serial_adder.sv | 151 +++++++++++++++
 tb/tb_bit_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// LSB-first sequential adder. The operands are loaded into shift registers and
// summed one bit per clock through a single full-adder slice: two half_adder
// cells plus an OR. A flip-flop carries the carry from one bit to the next.
// This costs WIDTH cycles of latency but needs only one full-adder slice,
// whatever WIDTH is.
//
// Parameters
//   WIDTH        operand/sum width in bits (1..32)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request a new addition (only looked at in IDLE)
//   a, b         operands, captured on the accepting edge
//   carryInput   carry-in, captured on the accepting edge
//   busy         high while bits are being processed (SHIFT)
//   done         one-cycle pulse; sum/carryOutput hold the new result
//   sum          registered result of the last completed addition
//   carryOutput  registered carry-out of the last completed addition
// -----------------------------------------------------------------------------

// Half adder: the building block of the full-adder slice.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryInput,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOutput
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] bit_count;

  // Full-adder slice on the current LSBs.
  logic prop;
  logic gen0;
  logic bit_sum;
  logic gen1;
  logic bit_carry;

  half_adder u_ha0 (
    .x (a_reg[0]),
    .y (b_reg[0]),
    .s (prop),
    .c (gen0)
  );

  half_adder u_ha1 (
    .x (prop),
    .y (carry_reg),
    .s (bit_sum),
    .c (gen1)
  );

  assign bit_carry = gen0 | gen1;

  // Accumulator after this cycle's bit enters at the MSB. Concatenating and
  // slicing keeps this valid for WIDTH=1, where acc_reg[WIDTH-1:1] would be
  // an empty range.
  logic [WIDTH:0]   acc_cat;
  logic [WIDTH-1:0] acc_next;

  assign acc_cat  = {bit_sum, acc_reg};
  assign acc_next = acc_cat[WIDTH:1];

  logic last_bit;
  assign last_bit = (bit_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      carry_reg   <= 1'b0;
      bit_count   <= '0;
      sum         <= '0;
      carryOutput <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= carryInput;
            acc_reg   <= '0;
            bit_count <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          acc_reg   <= acc_next;
          carry_reg <= bit_carry;
          bit_count <= bit_count + 1'b1;
          // Outputs are only ever written with the finished result, so a
          // partial sum is never visible.
          if (last_bit) begin
            sum         <= acc_next;
            carryOutput <= bit_carry;
            state       <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Testbench for bit_serial_adder: directed scenarios on a WIDTH=8 instance and
// randomized sweeps on WIDTH=8 and WIDTH=1 instances, checked against a plain
// arithmetic reference (a + b + carryInput).
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8 = 1'b1, start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8;
  logic [7:0] sum8;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .carryInput(cin8), .busy(busy8), .done(done8), .sum(sum8),
    .carryOutput(co8)
  );

  // WIDTH=1 instance
  logic       rst1 = 1'b1, start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, co1;
  logic [0:0] sum1;

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
    .carryInput(cin1), .busy(busy1), .done(done1), .sum(sum1),
    .carryOutput(co1)
  );

  int  tests  = 0;
  int  failed = 0;
  bit  mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven after this are sampled at the next edge,
  // outputs read after this are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // busy and done must never coincide.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy_done_excl_w8", {31'b0, busy8 & done8}, 32'd0);
      check_eq("busy_done_excl_w1", {31'b0, busy1 & done1}, 32'd0);
    end
  end

  // One complete WIDTH=8 operation; optionally scrambles inputs after accept.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, input bit scramble);
    logic [8:0] exp;
    logic [7:0] prev_sum;
    logic       prev_co;
    int         lat;
    bit         held;
    exp      = 9'(ta) + 9'(tb_) + 9'(tc);
    prev_sum = sum8;
    prev_co  = co8;
    a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check_eq("w8_busy_after_start", {31'b0, busy8}, 32'd1);
    if (scramble) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    lat  = 0;
    held = 1'b1;
    while (!done8 && lat < 40) begin
      if (sum8 !== prev_sum || co8 !== prev_co) held = 1'b0;
      tick();
      lat++;
    end
    check_eq("w8_latency", 32'(lat), 32'd8);
    check_eq("w8_sum_held_in_flight", {31'b0, held}, 32'd1);
    check_eq("w8_result", {23'b0, co8, sum8}, {23'b0, exp});
    tick();
    check_eq("w8_done_one_cycle", {31'b0, done8}, 32'd0);
  endtask

  task automatic run_op1(input logic ta, input logic tb_, input logic tc,
                         input bit scramble);
    logic [1:0] exp;
    int         lat;
    exp = 2'(ta) + 2'(tb_) + 2'(tc);
    a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("w1_busy_after_start", {31'b0, busy1}, 32'd1);
    if (scramble) begin
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    end
    lat = 0;
    while (!done1 && lat < 10) begin
      tick();
      lat++;
    end
    check_eq("w1_latency", 32'(lat), 32'd1);
    check_eq("w1_result", {30'b0, co1, sum1}, {30'b0, exp});
    tick();
    check_eq("w1_done_one_cycle", {31'b0, done1}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    int last_done;
    int gaps_ok;
    int sums_ok;
    logic [7:0] done_sum;

    // Reset state
    tick(); tick();
    rst8 = 1'b0; rst1 = 1'b0;
    check_eq("rst_busy", {31'b0, busy8}, 32'd0);
    check_eq("rst_done", {31'b0, done8}, 32'd0);
    check_eq("rst_sum", {24'b0, sum8}, 32'd0);
    check_eq("rst_carry", {31'b0, co8}, 32'd0);
    mon_en = 1'b1;

    // rst and start on the same edge: rst wins
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    tick();
    rst8 = 1'b0; start8 = 1'b0;
    check_eq("rst_beats_start", {31'b0, busy8}, 32'd0);
    tick();
    check_eq("rst_beats_start_later", {31'b0, busy8}, 32'd0);

    // Basic additions
    run_op8(8'h05, 8'h03, 1'b0, 1'b0);
    check_eq("t1_sum", {24'b0, sum8}, 32'h08);
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    check_eq("t2_sum", {23'b0, co8, sum8}, 32'h100);
    run_op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("t2_sum_holds", {23'b0, co8, sum8}, 32'h1FF);

    // Inputs changed mid-flight and a second start in SHIFT are ignored
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    done_cnt = 0; done_at = -1; done_sum = '0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 1) begin a8 = 8'h99; b8 = 8'h11; end
      if (k == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      if (k == 4) start8 = 1'b0;
      tick();
      if (done8) begin
        done_cnt++;
        done_at  = k;
        done_sum = sum8;
      end
    end
    check_eq("t3_done_count", 32'(done_cnt), 32'd1);
    check_eq("t3_done_edge", 32'(done_at), 32'd8);
    check_eq("t3_sum", {24'b0, done_sum}, 32'h46);

    // Reset mid-SHIFT aborts without a done pulse
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    check_eq("t4_busy_after_rst", {31'b0, busy8}, 32'd0);
    check_eq("t4_sum_after_rst", {24'b0, sum8}, 32'd0);
    check_eq("t4_carry_after_rst", {31'b0, co8}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) done_cnt++;
    end
    check_eq("t4_no_done", 32'(done_cnt), 32'd0);
    run_op8(8'h01, 8'h01, 1'b0, 1'b0);
    check_eq("t4_sum_next", {24'b0, sum8}, 32'h02);

    // Held start: back-to-back operations every WIDTH+2 cycles
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    done_cnt = 0; last_done = -1; gaps_ok = 1; sums_ok = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done8) begin
        if (last_done >= 0 && (k - last_done) != 10) gaps_ok = 0;
        if (last_done < 0 && k != 8) gaps_ok = 0;
        if ({co8, sum8} !== 9'h030) sums_ok = 0;
        last_done = k;
        done_cnt++;
      end
    end
    start8 = 1'b0;
    check_eq("t5_done_count", 32'(done_cnt), 32'd4);
    check_eq("t5_spacing", 32'(gaps_ok), 32'd1);
    check_eq("t5_sums", 32'(sums_ok), 32'd1);
    for (int k = 0; k < 12 && (busy8 || done8); k++) tick();
    check_eq("t5_idle_after", {30'b0, busy8, done8}, 32'd0);

    // Randomized sweeps
    for (int n = 0; n < 200; n++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int n = 0; n < 200; n++)
      run_op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    mon_en = 1'b0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
